// File: rtl/alu_pkg.sv
// Shared opcode map, flag indices and enums for the sequential ALU.
// Low nibble selects the op in register form, high nibble in immediate form.
package alu_pkg;

  localparam logic [3:0] EXT_AND  = 4'h1;
  localparam logic [3:0] EXT_OR   = 4'h2;
  localparam logic [3:0] EXT_XOR  = 4'h3;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_ADDU = 4'h6;
  localparam logic [3:0] EXT_ADDC = 4'h7;
  localparam logic [3:0] EXT_SUB  = 4'h9;
  localparam logic [3:0] EXT_SUBC = 4'hA;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV  = 4'hD;
  localparam logic [3:0] EXT_MUL  = 4'hE;

  localparam logic [3:0] GRP_REG   = 4'h0;
  localparam logic [3:0] GRP_SHIFT = 4'h8;

  localparam logic [7:0] OPC_LSH   = 8'h84;
  localparam logic [7:0] OPC_ASHU  = 8'h86;
  localparam logic [2:0] SUB_LSHI  = 3'b000;
  localparam logic [2:0] SUB_ASHUI = 3'b001;

  localparam int NFLAG = 5;
  localparam int C_BIT = 0;
  localparam int L_BIT = 1;
  localparam int F_BIT = 2;
  localparam int N_BIT = 3;
  localparam int Z_BIT = 4;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADDU, OP_ADDC, OP_SUB,
    OP_SUBC, OP_CMP, OP_AND, OP_OR,
    OP_XOR, OP_MOV, OP_MUL, OP_LSH,
    OP_ASHU, OP_ILL
  } alu_op_t;

  typedef enum logic {
    S_IDLE,
    S_MUL_BUSY
  } alu_state_t;

  function automatic alu_op_t ext_op(
    input logic [3:0] e
  );
    alu_op_t op;
    case (e)
      EXT_AND:  op = OP_AND;
      EXT_OR:   op = OP_OR;
      EXT_XOR:  op = OP_XOR;
      EXT_ADD:  op = OP_ADD;
      EXT_ADDU: op = OP_ADDU;
      EXT_ADDC: op = OP_ADDC;
      EXT_SUB:  op = OP_SUB;
      EXT_SUBC: op = OP_SUBC;
      EXT_CMP:  op = OP_CMP;
      EXT_MOV:  op = OP_MOV;
      EXT_MUL:  op = OP_MUL;
      default:  op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic alu_op_t decode_op(
    input logic [7:0] opc,
    input logic       mul_en
  );
    alu_op_t op;
    op = OP_ILL;
    if (opc[7:4] == GRP_REG) begin
      op = ext_op(opc[3:0]);
    end else if (opc[7:4] == GRP_SHIFT) begin
      unique case (1'b1)
        (opc == OPC_LSH) || (opc[3:1] == SUB_LSHI):
          op = OP_LSH;
        (opc == OPC_ASHU) || (opc[3:1] == SUB_ASHUI):
          op = OP_ASHU;
        default:
          op = OP_ILL;
      endcase
    end else begin
      op = ext_op(opc[7:4]);
    end
    if ((op == OP_MUL) && !mul_en) op = OP_ILL;
    return op;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles.
// Holds at the last step while the consumer stalls the output.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q && !(done && hold)) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, carry-chaining flag register
// and an optional iterative multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             busy
);

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_CNT = WIDTH'(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flag_q, flag_d;
  logic             out_valid_q, out_valid_d;

  alu_op_t          op;
  logic             accept, stall, mul_start;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flg;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] neg_a;
  logic             c_in;

  assign op        = decode_op(opcode, MUL_EN);
  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = (state_q == S_IDLE) && !stall;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flag_q;
  assign busy      = mul_busy;
  assign c_in      = flag_q[C_BIT];
  assign neg_a     = -a;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .hold    (stall),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    sum     = '0;
    case (op)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        sum = {1'b0, b} + {1'b0, a};
        if (op == OP_ADDC) sum = sum + (WIDTH+1)'(c_in);
        alu_res = sum[M:0];
        if (op != OP_ADD) alu_flg[C_BIT] = sum[WIDTH];
        if (op != OP_ADDU)
          alu_flg[F_BIT] = (a[M] == b[M]) && (alu_res[M] != b[M]);
      end
      OP_SUB, OP_SUBC: begin
        sum = {1'b0, b} - {1'b0, a};
        if (op == OP_SUBC) begin
          sum = sum - (WIDTH+1)'(c_in);
          alu_flg[C_BIT] = sum[WIDTH];
        end
        alu_res = sum[M:0];
        alu_flg[F_BIT] = (a[M] != b[M]) && (alu_res[M] != b[M]);
      end
      OP_CMP: begin
        alu_res = (a == b) ? '0 : '1;
        alu_flg[L_BIT] = a > b;
        alu_flg[N_BIT] = $signed(a) > $signed(b);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_MOV: alu_res = a;
      OP_LSH: begin
        if (!a[M]) alu_res = (a >= W_CNT) ? '0 : b << a;
        else       alu_res = (neg_a >= W_CNT) ? '0 : b >> neg_a;
      end
      OP_ASHU: begin
        if (a >= W_CNT) alu_res = {WIDTH{b[M]}};
        else            alu_res = WIDTH'($signed(b) >>> a);
      end
      default: alu_res = '0;
    endcase
    alu_flg[Z_BIT] = (alu_res == '0);
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flag_d      = flag_q;
    out_valid_d = out_valid_q && !out_ready;
    mul_start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL_BUSY;
          end else begin
            result_d    = alu_res;
            flag_d      = alu_flg;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL_BUSY: begin
        if (mul_done && !stall) begin
          result_d      = product;
          flag_d        = '0;
          flag_d[Z_BIT] = (product == '0);
          out_valid_d   = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      flag_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: reset, carry chain, shifts, MUL,
// back-pressure and illegal opcodes on a MUL_EN=1 and a MUL_EN=0 instance.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  opcode;
  logic [15:0] a, b;

  logic        in_ready, out_valid, busy;
  logic [15:0] result;
  logic [4:0]  flags;

  logic        in_ready2, out_valid2, busy2;
  logic [15:0] result2;
  logic [4:0]  flags2;

  int passed = 0;
  int total  = 0;
  int cycles;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut_nomul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .result    (result2),
    .flags     (flags2),
    .busy      (busy2)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [15:0] aa,
                      input logic [15:0] bb);
    int n;
    n = 0;
    opcode   = op;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("send_timeout", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic op_chk(input string tag, input logic [7:0] op,
                        input logic [15:0] aa, input logic [15:0] bb,
                        input logic [15:0] er, input logic [4:0] ef);
    send(op, aa, bb);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, {11'd0, flags}, {11'd0, ef});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 8'h00;
    a         = '0;
    b         = '0;
    #22;
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", {11'd0, flags}, 16'h0000);
    chk("rst_ovalid", {15'd0, out_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);

    // MUL interrupted by reset
    send(8'h0E, 16'd3, 16'd5);
    chk("mul_busy", {15'd0, busy}, 16'd1);
    chk("mul_in_ready", {15'd0, in_ready}, 16'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midmul_result", result, 16'h0000);
    chk("midmul_flags", {11'd0, flags}, 16'h0000);
    chk("midmul_ovalid", {15'd0, out_valid}, 16'd0);
    chk("midmul_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h0E, 16'd3, 16'd5);
    wait_out();
    chk("mul_latency", 16'(cycles), 16'd16);
    chk("mul_3x5", result, 16'h000F);
    chk("mul_flags", {11'd0, flags}, 16'h0000);
    chk("mul_busy_end", {15'd0, busy}, 16'd0);

    send(8'hE3, 16'h1234, 16'h0007);
    chk("nomul_res", result2, 16'h0000);
    chk("nomul_flg", {11'd0, flags2}, 16'h0010);
    chk("nomul_ov", {15'd0, out_valid2}, 16'd1);
    chk("nomul_busy", {15'd0, busy2}, 16'd0);
    wait_out();
    chk("muli_res", result, 16'h7F6C);

    send(8'h0E, 16'h0100, 16'h0100);
    wait_out();
    chk("mul_wrap_res", result, 16'h0000);
    chk("mul_wrap_flg", {11'd0, flags}, 16'h0010);

    // Arithmetic and carry chain
    op_chk("addu", 8'h06, 16'h0001, 16'hFFFF, 16'h0000, 5'b10001);
    op_chk("addc", 8'h07, 16'h0000, 16'h0000, 16'h0001, 5'b00000);
    op_chk("add_ovf", 8'h05, 16'h0001, 16'h7FFF, 16'h8000, 5'b00100);
    op_chk("addui", 8'h6C, 16'h0001, 16'hFFFF, 16'h0000, 5'b10001);
    op_chk("subc", 8'h0A, 16'h0000, 16'h0000, 16'hFFFF, 5'b00001);
    op_chk("sub_ovf", 8'h09, 16'h0001, 16'h8000, 16'h7FFF, 5'b00100);

    // Compare
    op_chk("cmp_l", 8'h0B, 16'hFFFF, 16'h0001, 16'hFFFF, 5'b00010);
    op_chk("cmp_eq", 8'h0B, 16'h0005, 16'h0005, 16'h0000, 5'b10000);
    op_chk("cmpi_n", 8'hB7, 16'h0001, 16'hFFFF, 16'hFFFF, 5'b01000);

    // Shifts
    op_chk("lsh_neg", 8'h84, 16'hFFFC, 16'h8000, 16'h0800, 5'b00000);
    op_chk("lshi_pos", 8'h80, 16'h0004, 16'h0001, 16'h0010, 5'b00000);
    op_chk("lsh_big", 8'h84, 16'h0010, 16'hFFFF, 16'h0000, 5'b10000);
    op_chk("ashu_big", 8'h86, 16'd20, 16'h8000, 16'hFFFF, 5'b00000);
    op_chk("ashui", 8'h82, 16'h0004, 16'h8000, 16'hF800, 5'b00000);

    // Logic and move
    op_chk("and", 8'h01, 16'h0F0F, 16'h00FF, 16'h000F, 5'b00000);
    op_chk("xori", 8'h3A, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b10000);
    op_chk("mov", 8'h0D, 16'h1234, 16'h5555, 16'h1234, 5'b00000);

    // Illegal opcodes
    op_chk("ill_00", 8'h00, 16'h1111, 16'h2222, 16'h0000, 5'b10000);
    chk("ill_ov", {15'd0, out_valid}, 16'd1);
    op_chk("ill_4f", 8'h4F, 16'h1111, 16'h2222, 16'h0000, 5'b10000);

    // Back-pressure with a queued op
    send(8'h05, 16'h0001, 16'h0001);
    chk("bp_first", result, 16'h0002);
    out_ready = 1'b0;
    opcode    = 8'h0D;
    a         = 16'hABCD;
    b         = 16'h0000;
    in_valid  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
      chk("bp_hold", result, 16'h0002);
      chk("bp_ov", {15'd0, out_valid}, 16'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next", result, 16'hABCD);
    chk("bp_next_ov", {15'd0, out_valid}, 16'd1);
    @(posedge clk);
    #1;
    chk("bp_drain", {15'd0, out_valid}, 16'd0);
    chk("bp_drain_res", result, 16'hABCD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with valid/ready handshakes, an internal flag register and an iterative multiplier. It sits between the decode stage and register write-back in the CPU datapath. It executes the team's 8-bit opcode set at configurable width, chains carry across instructions (ADDC/SUBC use the stored carry) and stalls cleanly on back-pressure.

## Interface
- WIDTH, 16, datapath width in bits (≥4)
- MUL_EN, 1, 1 = iterative MUL/MULI implemented; 0 = MUL treated as illegal opcode

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- opcode  in  8  team opcode encoding; immediate forms included
- a  in  WIDTH  source operand (R1)
- b  in  WIDTH  destination operand (R2); immediates already extended by decode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- flags  out  5  registered flags: [0]=C, [1]=L, [2]=F (overflow), [3]=N, [4]=Z
- busy  out  1  multiply in progress

## Operation
- Register forms and immediate forms decode identically: ADD/ADDI, ADDU/ADDUI, ADDC/ADDCI, SUB/SUBI, SUBC/SUBCI, CMP/CMPI, AND/ANDI, OR/ORI, XOR/XORI, MOV/MOVI, MUL/MULI, LSH/LSHI, ASHU/ASHUI.
- Arithmetic:
  - ADD: b+a; sets F on signed overflow.
  - ADDU: b+a; sets C to the carry-out.
  - ADDC: b+a+C_q; sets C and F.
  - SUB: b−a; sets F.
  - SUBC: b−a−C_q; C = borrow (1 when b < a+C_q, unsigned); sets F.
  - All arithmetic is modulo 2^WIDTH.
- CMP:
  - result = 0 if a==b, else all-ones.
  - L=1 if a>b unsigned.
  - N=1 if a>b signed.
- Logic and moves: AND/OR/XOR are bitwise; MOV yields a.
- LSH: a is a signed shift count.
  - a ≥ 0: b << a.
  - a < 0: logical b >> (−a).
  - |count| ≥ WIDTH: result 0.
- ASHU: arithmetic b >>> a, with a unsigned. Counts ≥ WIDTH give all sign bits.
- MUL: low WIDTH bits of a·b, computed by shift-add over WIDTH iterations. No flags except Z.
- Z = (result==0) for every op. Flags not listed for an op are cleared.
- Illegal or undefined opcode: result 0, flags = Z only. A response is still produced.
- Flag register flag_q loads together with result; flags output = flag_q. C_q is flag_q[0] at the acceptance cycle.
- FSM states:
  - IDLE: accept when in_valid & in_ready. Single-cycle op → load output register, stay IDLE. MUL → MUL_BUSY.
  - MUL_BUSY: iteration counter counts 0..WIDTH−1. At terminal count, load output register → IDLE.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- busy = (state==MUL_BUSY).

## Timing
- Reset (async assert, any state, including mid-MUL):
  - state=IDLE
  - result=0, flag_q=0, out_valid=0, busy=0
  - partial product and counter cleared
  - in_ready=1 from the first edge after deassertion
- Single-cycle op accepted at edge k → out_valid=1 after edge k+1 (1-cycle latency). Back-to-back throughput is 1/cycle when out_ready=1.
- MUL accepted at edge k → busy for WIDTH cycles → out_valid after edge k+WIDTH. in_ready=0 throughout.
- out_valid & !out_ready: result and flags held stable, no new acceptance. A MUL finishing while the output is stalled waits in MUL_BUSY at terminal count.
- Simultaneous consume and accept (out_valid & out_ready & in_valid): the new result replaces the old on the same edge. No bubble.
- Operands and opcode are sampled only at acceptance. Input changes during MUL_BUSY are ignored.

## Structure
- Package alu_pkg holds:
  - opcode localparams (register and immediate patterns)
  - flag bit indices C_BIT..Z_BIT
  - decoded-op enum alu_op_t
  - state enum alu_state_t
- Sub-module alu_mul_iter (start, a, b → busy, done, product[WIDTH-1:0]) holds the shift-add datapath and iteration counter. The top holds decode, the combinational single-cycle unit, the handshake and the flag register.

## Test plan
- Reset mid-MUL (WIDTH=16, a=3, b=5, rst_n low at cycle 4) → result=0, flags=0, out_valid=0, busy=0; next MUL 3·5 gives 0x000F after 16 cycles.
- Carry chain: ADDU b=0xFFFF,a=0x0001 → result 0x0000, C=1, Z=1; then ADDC b=0x0000,a=0x0000 → 0x0001, C=0.
- ADD b=0x7FFF,a=0x0001 → 0x8000, F=1. SUBC with C_q=1, b=0x0000,a=0x0000 → 0xFFFF, C=1, F=0.
- CMP a=0xFFFF,b=0x0001 → result 0xFFFF, L=1, N=0. LSH a=0xFFFC (−4),b=0x8000 → 0x0800. ASHU a=20,b=0x8000 → 0xFFFF.
- Back-pressure: out_ready low for 3 cycles with in_valid high → in_ready=0, result stable. Releasing out_ready → queued op accepted the same cycle, no lost or duplicated results.
- Illegal opcode 0x00 → result 0, flags=5'b10000, out_valid asserted. With MUL_EN=0, MULI 0xE3 → same illegal response.
